// File: rtl/instruction_utils_pkg.sv
// Shared types and constants for the mini-rv pipeline stages.
package instruction_utils;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_HOLD
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, runs a single-outstanding imem handshake and
// feeds decode, with a one-entry buffer to absorb a response arriving under stall.
module fetch_stage
  import instruction_utils::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_if_take_branch,
  input  logic [31:0] ex_if_branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc
);

  fetch_state_e state, state_next;

  logic [31:0] pc, pc_next;
  logic [31:0] target_aligned;
  logic        discard;
  logic        buf_valid;
  logic [31:0] buf_instr, buf_pc;

  logic redirect, accept, resp, fresh, deliver, capture, release_buf;

  assign redirect       = ex_if_take_branch;
  assign target_aligned = ex_if_branch_target & 32'hFFFF_FFFC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH_IDLE: state_next = FETCH_REQ;
      FETCH_REQ:  if (imem_ready) state_next = FETCH_WAIT;
      FETCH_WAIT: if (imem_rvalid) state_next = capture ? FETCH_HOLD : FETCH_REQ;
      FETCH_HOLD: if (redirect || !stall) state_next = FETCH_REQ;
      default:    state_next = FETCH_IDLE;
    endcase
  end

  // A word is only usable if it belongs to the current stream: neither
  // flagged stale by an earlier redirect nor overtaken by one this cycle.
  always_comb begin
    accept      = 1'b0;
    resp        = 1'b0;
    release_buf = 1'b0;
    case (state)
      FETCH_REQ:  accept      = imem_ready;
      FETCH_WAIT: resp        = imem_rvalid;
      FETCH_HOLD: release_buf = !stall && !redirect;
      default:    ;
    endcase
    fresh   = resp && !discard && !redirect;
    deliver = fresh && !stall;
    capture = fresh && stall;
    if (redirect)    pc_next = target_aligned;
    else if (accept) pc_next = pc + 32'd4;
    else             pc_next = pc;
  end

  // imem_addr only moves on entry to REQ, so it still names the
  // outstanding fetch while in WAIT and doubles as the response PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      discard     <= 1'b0;
      buf_valid   <= 1'b0;
      buf_instr   <= NOP_INSTR;
      buf_pc      <= '0;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
    end else begin
      pc       <= pc_next;
      imem_req <= (state_next == FETCH_REQ);
      if (state_next == FETCH_REQ) imem_addr <= pc_next;

      if (resp)                                           discard <= 1'b0;
      else if (redirect && (accept || state == FETCH_WAIT)) discard <= 1'b1;

      if (redirect || release_buf) begin
        buf_valid <= 1'b0;
      end else if (capture) begin
        buf_valid <= 1'b1;
        buf_instr <= imem_rdata;
        buf_pc    <= imem_addr;
      end

      if (redirect) begin
        if_id_valid <= 1'b0;
      end else if (deliver) begin
        if_id_valid <= 1'b1;
        if_id_instr <= imem_rdata;
        if_id_pc    <= imem_addr;
      end else if (release_buf) begin
        if_id_valid <= 1'b1;
        if_id_instr <= buf_instr;
        if_id_pc    <= buf_pc;
      end else if (!stall) begin
        if_id_valid <= 1'b0;
      end
    end
  end

endmodule
